// File: rtl/cvp14_pkg.sv
// Shared constants, the write-buffer entry type and the saturating counter helper
// for the CVP14 memory bridge.
package cvp14_pkg;

  localparam int CVP14_ADDR_W = 16;
  localparam int CVP14_DATA_W = 16;
  localparam int PERF_W       = 32;

  typedef struct packed {
    logic [CVP14_ADDR_W-1:0] addr;
    logic [CVP14_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/cvp14_wb_fifo.sv
// Posted-write FIFO for the CVP14 memory bridge: storage, wrap-around pointers,
// occupancy count and a youngest-entry address match for read forwarding.
module cvp14_wb_fifo
  import cvp14_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = CVP14_ADDR_W,
  parameter int DW    = CVP14_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [AW-1:0]           push_addr,
  input  logic [DW-1:0]           push_data,
  input  logic                    pop,
  input  logic [AW-1:0]           lookup_addr,
  output logic [AW-1:0]           head_addr,
  output logic [DW-1:0]           head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    hit,
  output logic [DW-1:0]           hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] idx;
  logic          match;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == {CW{1'b0}});
  // A full buffer only accepts a push when the same cycle drains the head.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign count   = cnt;

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= {PW{1'b0}};
      tail <= {PW{1'b0}};
      cnt  <= {CW{1'b0}};
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = {DW{1'b0}};
    idx      = {PW{1'b0}};
    match    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx      = head + PW'(i);
      match    = (CW'(i) < cnt) && (addr_mem[idx] == lookup_addr);
      hit      = hit | match;
      hit_data = match ? data_mem[idx] : hit_data;
    end
  end

endmodule

// File: rtl/cvp14_mem_bridge.sv
// CVP14 core-to-SRAM bridge: reads own the SRAM port, writes are posted and drained
// when the port is idle. Optional perf counters: define CVP14_MEMBR_PERF_EN.
module cvp14_mem_bridge
  import cvp14_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = CVP14_ADDR_W,
  parameter int DATA_W   = CVP14_DATA_W
) (
  input  logic                      Clk1,
  input  logic                      Reset,
  input  logic [ADDR_W-1:0]         Addr,
  input  logic                      RD,
  input  logic                      WR,
  input  logic [DATA_W-1:0]         dataOut,
  output logic [DATA_W-1:0]         DataIn,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic                      sram_re,
  output logic                      sram_we,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_empty
`ifdef CVP14_MEMBR_PERF_EN
  ,
  output logic [PERF_W-1:0]         perf_rd,
  output logic [PERF_W-1:0]         perf_wr,
  output logic [PERF_W-1:0]         perf_fwd
`endif
);

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              rd_q;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] data_hold;
  logic [DATA_W-1:0] rd_mux;

  cvp14_wb_fifo #(
    .DEPTH (WB_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wb (
    .clk         (Clk1),
    .rst         (Reset),
    .push        (WR),
    .push_addr   (Addr),
    .push_data   (dataOut),
    .pop         (sram_we),
    .lookup_addr (Addr),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (wb_count),
    .empty       (wb_empty),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  // Port arbitration: a read always wins, otherwise drain the oldest posted write.
  always_comb begin
    sram_re    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = head_addr;
    sram_wdata = head_data;
    if (RD && !Reset) begin
      sram_re   = 1'b1;
      sram_addr = Addr;
    end else if (!wb_empty) begin
      sram_we = 1'b1;
    end else begin
      sram_we = 1'b0;
    end
  end

  // DataIn is live only in the cycle after a read; otherwise it replays the last value.
  assign rd_mux = fwd_hit ? fwd_data : sram_rdata;
  assign DataIn = rd_q ? rd_mux : data_hold;

  // Forwarding capture and read-data hold.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      rd_q      <= 1'b0;
      fwd_hit   <= 1'b0;
      fwd_data  <= {DATA_W{1'b0}};
      data_hold <= {DATA_W{1'b0}};
    end else begin
      rd_q <= RD;
      if (RD) begin
        fwd_hit  <= hit;
        fwd_data <= hit_data;
      end
      if (rd_q) data_hold <= rd_mux;
    end
  end

`ifdef CVP14_MEMBR_PERF_EN
  // Saturating activity counters.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      perf_rd  <= {PERF_W{1'b0}};
      perf_wr  <= {PERF_W{1'b0}};
      perf_fwd <= {PERF_W{1'b0}};
    end else begin
      if (RD)       perf_rd  <= sat_inc(perf_rd);
      if (WR)       perf_wr  <= sat_inc(perf_wr);
      if (RD && hit) perf_fwd <= sat_inc(perf_fwd);
    end
  end
`endif

endmodule
